// File: rtl/fifo_bridge_pkg.sv
// Shared definitions for the FIFO bridge: word layout, modifier codes, FSM states.
package fifo_bridge_pkg;

   localparam int unsigned WORD_W    = 34;
   localparam int unsigned MOD_W     = 2;
   localparam int unsigned PAYLOAD_W = 32;
   localparam int unsigned MOD_LSB   = 32;
   localparam int unsigned TXD_W     = 32;
   localparam int unsigned CFG_W     = 16;
   localparam int unsigned RXV_W     = 16;

   typedef enum logic [MOD_W-1:0] {
      MOD_CONFIG  = 2'd0,
      MOD_DATA    = 2'd1,
      MOD_STATUS  = 2'd2,
      MOD_CHANNEL = 2'd3
   } modifier_e;

   // Command and report words share one layout: modifier in [33:32], payload below.
   typedef struct packed {
      modifier_e              modifier;
      logic [PAYLOAD_W-1:0]   payload;
   } fifo_word_t;

   typedef enum logic {
      W_IDLE,
      W_POP
   } w_state_e;

   typedef enum logic [2:0] {
      R_IDLE,
      R_CHAN,
      R_CFG,
      R_STAT,
      R_DATA
   } r_state_e;

   function automatic fifo_word_t make_word(input modifier_e m, input logic [PAYLOAD_W-1:0] p);
      fifo_word_t w;
      w.modifier = m;
      w.payload  = p;
      return w;
   endfunction

endpackage

// File: rtl/fifo_bridge_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first set request strictly after ptr, wrapping.
// Ports: req (N requests), ptr (last served index) -> grant_c (one-hot), idx_c, valid_c.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          valid_c
);

   // Search ptr+1 .. ptr+N; the last candidate is ptr itself.
   always_comb begin : arb_search
      int unsigned cand;
      cand    = 0;
      grant_c = '0;
      idx_c   = '0;
      valid_c = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(ptr) + k) % N;
         if (!valid_c && req[IW'(cand)]) begin
            valid_c               = 1'b1;
            idx_c                 = IW'(cand);
            grant_c[IW'(cand)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_bridge_mc.sv
// Multi-channel bridge between host command/report FIFOs and TX/RX channels.
// Write engine: pops {modifier,payload} commands, issues per-channel register strobes,
//   counts rejected commands in err_cnt.
// Read engine: on channel change pulses, pushes report bursts (channel, config, status,
//   and data for RX channels) to the report FIFO in round-robin channel order.
// Ports: clk/rst_n; fifo_read_* command FIFO side; fifo_write_* report FIFO side;
//   *_tx transmitter buses/strobes/readback; *_rx receiver buses/strobes/readback; err_cnt.
module fifo_bridge_mc
   import fifo_bridge_pkg::*;
#(
   parameter int unsigned TX_COUNT = 2,
   parameter int unsigned RX_COUNT = 2,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        fifo_read_empty,
   input  logic [WORD_W-1:0]           fifo_read_data,
   output logic                        fifo_read_inc,
   input  logic                        fifo_write_full,
   output logic [WORD_W-1:0]           fifo_write_data,
   output logic                        fifo_write_inc,
   output logic [TXD_W*TX_COUNT-1:0]   wr_data_tx,
   output logic [TX_COUNT-1:0]         data_we_tx,
   output logic [CFG_W*TX_COUNT-1:0]   wr_config_tx,
   output logic [TX_COUNT-1:0]         config_we_tx,
   input  logic [TX_COUNT-1:0]         rd_status_tx,
   input  logic [CFG_W*TX_COUNT-1:0]   rd_config_tx,
   input  logic [TX_COUNT-1:0]         config_changed_tx,
   input  logic [TX_COUNT-1:0]         status_changed_tx,
   output logic [CFG_W*RX_COUNT-1:0]   wr_config_rx,
   output logic [RX_COUNT-1:0]         config_we_rx,
   input  logic [RXV_W*RX_COUNT-1:0]   rd_status_rx,
   input  logic [RXV_W*RX_COUNT-1:0]   rd_config_rx,
   input  logic [RXV_W*RX_COUNT-1:0]   rd_data_rx,
   input  logic [RX_COUNT-1:0]         config_changed_rx,
   input  logic [RX_COUNT-1:0]         data_status_changed_rx,
   output logic [ERR_W-1:0]            err_cnt
);

   localparam int unsigned TOTAL = TX_COUNT + RX_COUNT;
   localparam int unsigned CH_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   // Write engine state
   w_state_e                   w_state_q, w_state_d;
   logic [CH_W-1:0]            wr_sel_q, wr_sel_d;
   logic                       fifo_read_inc_q, fifo_read_inc_d;
   logic [TX_COUNT-1:0]        data_we_tx_q, data_we_tx_d;
   logic [TXD_W*TX_COUNT-1:0]  wr_data_tx_q, wr_data_tx_d;
   logic [TX_COUNT-1:0]        config_we_tx_q, config_we_tx_d;
   logic [CFG_W*TX_COUNT-1:0]  wr_config_tx_q, wr_config_tx_d;
   logic [RX_COUNT-1:0]        config_we_rx_q, config_we_rx_d;
   logic [CFG_W*RX_COUNT-1:0]  wr_config_rx_q, wr_config_rx_d;
   logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;

   // Read engine state
   r_state_e                   r_state_q, r_state_d;
   logic [CH_W-1:0]            rd_sel_q, rd_sel_d;
   logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [TOTAL-1:0]           pending_q, pending_d;
   logic                       fifo_write_inc_q, fifo_write_inc_d;
   fifo_word_t                 fifo_write_data_q, fifo_write_data_d;

   fifo_word_t                 cmd_c;
   logic                       wr_busy_c;
   logic                       wr_is_tx_c;
   logic [CFG_W-1:0]           rd_cfg_c;
   logic [RXV_W-1:0]           rd_stat_c;
   logic [RXV_W-1:0]           rd_data_c;
   logic                       rd_is_rx_c;
   logic [TOTAL-1:0]           chg_c;
   logic [TOTAL-1:0]           arb_grant_c;
   logic [CH_W-1:0]            arb_idx_c;
   logic                       arb_valid_c;

   assign cmd_c = fifo_word_t'(fifo_read_data);
   assign chg_c = {config_changed_rx | data_status_changed_rx,
                   config_changed_tx | status_changed_tx};

   // Busy flag and type of the channel addressed by the write engine.
   always_comb begin
      wr_busy_c  = 1'b0;
      wr_is_tx_c = (32'(wr_sel_q) < TX_COUNT);
      for (int i = 0; i < int'(TX_COUNT); i++) begin
         if (wr_sel_q == CH_W'(i)) wr_busy_c = rd_status_tx[i];
      end
      for (int j = 0; j < int'(RX_COUNT); j++) begin
         if (wr_sel_q == CH_W'(TX_COUNT + 32'(j))) wr_busy_c = rd_status_rx[j*RXV_W];
      end
   end

   // Readback values of the channel currently being reported.
   always_comb begin
      rd_cfg_c   = '0;
      rd_stat_c  = '0;
      rd_data_c  = '0;
      rd_is_rx_c = (32'(rd_sel_q) >= TX_COUNT);
      for (int i = 0; i < int'(TX_COUNT); i++) begin
         if (rd_sel_q == CH_W'(i)) begin
            rd_cfg_c  = rd_config_tx[i*CFG_W +: CFG_W];
            rd_stat_c = RXV_W'(rd_status_tx[i]);
         end
      end
      for (int j = 0; j < int'(RX_COUNT); j++) begin
         if (rd_sel_q == CH_W'(TX_COUNT + 32'(j))) begin
            rd_cfg_c  = rd_config_rx[j*RXV_W +: RXV_W];
            rd_stat_c = rd_status_rx[j*RXV_W +: RXV_W];
            rd_data_c = rd_data_rx[j*RXV_W +: RXV_W];
         end
      end
   end

   rr_arbiter #(
      .N  (TOTAL),
      .IW (CH_W)
   ) u_arb (
      .req     (pending_q),
      .ptr     (rr_ptr_q),
      .grant_c (arb_grant_c),
      .idx_c   (arb_idx_c),
      .valid_c (arb_valid_c)
   );

   // Write engine: decode one command, then a pop cycle so the FIFO head can advance.
   always_comb begin : write_fsm
      logic take;
      logic err;
      take            = 1'b0;
      err             = 1'b0;
      w_state_d       = w_state_q;
      wr_sel_d        = wr_sel_q;
      fifo_read_inc_d = 1'b0;
      data_we_tx_d    = '0;
      config_we_tx_d  = '0;
      config_we_rx_d  = '0;
      wr_data_tx_d    = wr_data_tx_q;
      wr_config_tx_d  = wr_config_tx_q;
      wr_config_rx_d  = wr_config_rx_q;
      err_cnt_d       = err_cnt_q;
      case (w_state_q)
         W_IDLE: begin
            if (!fifo_read_empty) begin
               case (cmd_c.modifier)
                  MOD_CHANNEL: begin
                     // Whole payload must be a valid index; aliased upper bits are rejected.
                     if (cmd_c.payload < 32'(TOTAL)) begin
                        wr_sel_d = CH_W'(cmd_c.payload);
                        take     = 1'b1;
                     end else begin
                        err = 1'b1;
                     end
                  end
                  MOD_CONFIG: begin
                     // Busy channel: leave the command at the FIFO head until it frees up.
                     if (!wr_busy_c) begin
                        take = 1'b1;
                        for (int i = 0; i < int'(TX_COUNT); i++) begin
                           if (wr_sel_q == CH_W'(i)) begin
                              config_we_tx_d[i]                 = 1'b1;
                              wr_config_tx_d[i*CFG_W +: CFG_W]  = cmd_c.payload[CFG_W-1:0];
                           end
                        end
                        for (int j = 0; j < int'(RX_COUNT); j++) begin
                           if (wr_sel_q == CH_W'(TX_COUNT + 32'(j))) begin
                              config_we_rx_d[j]                 = 1'b1;
                              wr_config_rx_d[j*CFG_W +: CFG_W]  = cmd_c.payload[CFG_W-1:0];
                           end
                        end
                     end
                  end
                  MOD_DATA: begin
                     if (!wr_is_tx_c) begin
                        err = 1'b1;
                     end else if (!wr_busy_c) begin
                        take = 1'b1;
                        for (int i = 0; i < int'(TX_COUNT); i++) begin
                           if (wr_sel_q == CH_W'(i)) begin
                              data_we_tx_d[i]                   = 1'b1;
                              wr_data_tx_d[i*TXD_W +: TXD_W]    = cmd_c.payload;
                           end
                        end
                     end
                  end
                  default: err = 1'b1;
               endcase
               if (take || err) begin
                  fifo_read_inc_d = 1'b1;
                  w_state_d       = W_POP;
               end
               if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
            end
         end
         W_POP:   w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read engine: one report word per state, holding while the report FIFO is full.
   always_comb begin : read_fsm
      logic [TOTAL-1:0] clr;
      clr               = '0;
      r_state_d         = r_state_q;
      rd_sel_d          = rd_sel_q;
      rr_ptr_d          = rr_ptr_q;
      fifo_write_inc_d  = 1'b0;
      fifo_write_data_d = fifo_write_data_q;
      case (r_state_q)
         R_IDLE: begin
            if (arb_valid_c) begin
               rd_sel_d  = arb_idx_c;
               clr       = arb_grant_c;
               r_state_d = R_CHAN;
            end
         end
         R_CHAN: begin
            if (!fifo_write_full) begin
               fifo_write_inc_d  = 1'b1;
               fifo_write_data_d = make_word(MOD_CHANNEL, 32'(rd_sel_q));
               r_state_d         = R_CFG;
            end
         end
         R_CFG: begin
            if (!fifo_write_full) begin
               fifo_write_inc_d  = 1'b1;
               fifo_write_data_d = make_word(MOD_CONFIG, 32'(rd_cfg_c));
               r_state_d         = R_STAT;
            end
         end
         R_STAT: begin
            if (!fifo_write_full) begin
               fifo_write_inc_d  = 1'b1;
               fifo_write_data_d = make_word(MOD_STATUS, 32'(rd_stat_c));
               if (rd_is_rx_c) begin
                  r_state_d = R_DATA;
               end else begin
                  r_state_d = R_IDLE;
                  rr_ptr_d  = rd_sel_q;
               end
            end
         end
         R_DATA: begin
            if (!fifo_write_full) begin
               fifo_write_inc_d  = 1'b1;
               fifo_write_data_d = make_word(MOD_DATA, 32'(rd_data_c));
               r_state_d         = R_IDLE;
               rr_ptr_d          = rd_sel_q;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // A change arriving in the grant cycle keeps the bit set for another burst.
      pending_d = (pending_q & ~clr) | chg_c;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q         <= W_IDLE;
         wr_sel_q          <= '0;
         fifo_read_inc_q   <= 1'b0;
         data_we_tx_q      <= '0;
         wr_data_tx_q      <= '0;
         config_we_tx_q    <= '0;
         wr_config_tx_q    <= '0;
         config_we_rx_q    <= '0;
         wr_config_rx_q    <= '0;
         err_cnt_q         <= '0;
         r_state_q         <= R_IDLE;
         rd_sel_q          <= '0;
         rr_ptr_q          <= CH_W'(TOTAL - 1);
         pending_q         <= '1;
         fifo_write_inc_q  <= 1'b0;
         fifo_write_data_q <= '0;
      end else begin
         w_state_q         <= w_state_d;
         wr_sel_q          <= wr_sel_d;
         fifo_read_inc_q   <= fifo_read_inc_d;
         data_we_tx_q      <= data_we_tx_d;
         wr_data_tx_q      <= wr_data_tx_d;
         config_we_tx_q    <= config_we_tx_d;
         wr_config_tx_q    <= wr_config_tx_d;
         config_we_rx_q    <= config_we_rx_d;
         wr_config_rx_q    <= wr_config_rx_d;
         err_cnt_q         <= err_cnt_d;
         r_state_q         <= r_state_d;
         rd_sel_q          <= rd_sel_d;
         rr_ptr_q          <= rr_ptr_d;
         pending_q         <= pending_d;
         fifo_write_inc_q  <= fifo_write_inc_d;
         fifo_write_data_q <= fifo_write_data_d;
      end
   end

   assign fifo_read_inc   = fifo_read_inc_q;
   assign fifo_write_inc  = fifo_write_inc_q;
   assign fifo_write_data = fifo_write_data_q;
   assign data_we_tx      = data_we_tx_q;
   assign wr_data_tx      = wr_data_tx_q;
   assign config_we_tx    = config_we_tx_q;
   assign wr_config_tx    = wr_config_tx_q;
   assign config_we_rx    = config_we_rx_q;
   assign wr_config_rx    = wr_config_rx_q;
   assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_fifo_bridge_mc.sv
// Directed bench for fifo_bridge_mc (2 TX + 2 RX channels).
module tb_fifo_bridge_mc;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         fifo_read_empty;
   logic [33:0]  fifo_read_data;
   logic         fifo_read_inc;
   logic         fifo_write_full;
   logic [33:0]  fifo_write_data;
   logic         fifo_write_inc;
   logic [63:0]  wr_data_tx;
   logic [1:0]   data_we_tx;
   logic [31:0]  wr_config_tx;
   logic [1:0]   config_we_tx;
   logic [1:0]   rd_status_tx;
   logic [31:0]  rd_config_tx;
   logic [1:0]   config_changed_tx;
   logic [1:0]   status_changed_tx;
   logic [31:0]  wr_config_rx;
   logic [1:0]   config_we_rx;
   logic [31:0]  rd_status_rx;
   logic [31:0]  rd_config_rx;
   logic [31:0]  rd_data_rx;
   logic [1:0]   config_changed_rx;
   logic [1:0]   data_status_changed_rx;
   logic [7:0]   err_cnt;

   fifo_bridge_mc #(.TX_COUNT(2), .RX_COUNT(2), .ERR_W(8)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .fifo_read_empty        (fifo_read_empty),
      .fifo_read_data         (fifo_read_data),
      .fifo_read_inc          (fifo_read_inc),
      .fifo_write_full        (fifo_write_full),
      .fifo_write_data        (fifo_write_data),
      .fifo_write_inc         (fifo_write_inc),
      .wr_data_tx             (wr_data_tx),
      .data_we_tx             (data_we_tx),
      .wr_config_tx           (wr_config_tx),
      .config_we_tx           (config_we_tx),
      .rd_status_tx           (rd_status_tx),
      .rd_config_tx           (rd_config_tx),
      .config_changed_tx      (config_changed_tx),
      .status_changed_tx      (status_changed_tx),
      .wr_config_rx           (wr_config_rx),
      .config_we_rx           (config_we_rx),
      .rd_status_rx           (rd_status_rx),
      .rd_config_rx           (rd_config_rx),
      .rd_data_rx             (rd_data_rx),
      .config_changed_rx      (config_changed_rx),
      .data_status_changed_rx (data_status_changed_rx),
      .err_cnt                (err_cnt)
   );

   always #5 clk = ~clk;

   // Report FIFO sink and pop counter, sampled shortly after each rising edge.
   logic [33:0] rep_q[$];
   int          pop_cnt = 0;
   always @(posedge clk) begin
      #2;
      if (rst_n && fifo_write_inc) rep_q.push_back(fifo_write_data);
      if (rst_n && fifo_read_inc)  pop_cnt++;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] w(input logic [1:0] m, input logic [31:0] p);
      return {m, p};
   endfunction

   function automatic logic [33:0] rep_at(input int i);
      if (i < rep_q.size()) return rep_q[i];
      return 'x;
   endfunction

   task automatic present(input logic [1:0] m, input logic [31:0] p);
      fifo_read_data  = {m, p};
      fifo_read_empty = 1'b0;
   endtask

   // Waits for the pop pulse; on success the command FIFO goes empty again.
   task automatic wait_pop(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (fifo_read_inc) ok = 1'b1;
      end
      if (ok) fifo_read_empty = 1'b1;
   endtask

   task automatic send(input logic [1:0] m, input logic [31:0] p, input string tag);
      bit ok;
      present(m, p);
      wait_pop(20, ok);
      fifo_read_empty = 1'b1;
      chk({tag, "_popped"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_reports(input int target, input int budget, input string tag);
      int c;
      c = 0;
      while (rep_q.size() < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, 64'(rep_q.size()), 64'(target));
   endtask

   initial begin
      logic [33:0] exp_w[14];
      bit          ok;
      int          base;
      int          snap;

      rst_n = 1'b0;
      fifo_read_empty = 1'b1;
      fifo_read_data = '0;
      fifo_write_full = 1'b0;
      rd_status_tx = 2'b00;
      rd_config_tx = {16'h1B1B, 16'h1A1A};
      rd_status_rx = {16'h0030, 16'h0020};
      rd_config_rx = {16'h3C3C, 16'h2C2C};
      rd_data_rx   = {16'h3D3D, 16'h2D2D};
      config_changed_tx = '0;
      status_changed_tx = '0;
      config_changed_rx = '0;
      data_status_changed_rx = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_read_inc",  64'(fifo_read_inc), 64'd0);
      chk("rst_write_inc", 64'(fifo_write_inc), 64'd0);
      chk("rst_write_data", 64'(fifo_write_data), 64'd0);
      chk("rst_err_cnt",   64'(err_cnt), 64'd0);
      chk("rst_strobes",   64'({data_we_tx, config_we_tx, config_we_rx}), 64'd0);
      chk("rst_buses",     64'(wr_data_tx | 64'(wr_config_tx) | 64'(wr_config_rx)), 64'd0);

      // Full initial report: ch0..3 in order, TX 3 words, RX 4 words
      rst_n = 1'b1;
      exp_w[0]  = w(2'd3, 32'd0); exp_w[1]  = w(2'd0, 32'h1A1A); exp_w[2]  = w(2'd2, 32'd0);
      exp_w[3]  = w(2'd3, 32'd1); exp_w[4]  = w(2'd0, 32'h1B1B); exp_w[5]  = w(2'd2, 32'd0);
      exp_w[6]  = w(2'd3, 32'd2); exp_w[7]  = w(2'd0, 32'h2C2C); exp_w[8]  = w(2'd2, 32'h0020);
      exp_w[9]  = w(2'd1, 32'h2D2D);
      exp_w[10] = w(2'd3, 32'd3); exp_w[11] = w(2'd0, 32'h3C3C); exp_w[12] = w(2'd2, 32'h0030);
      exp_w[13] = w(2'd1, 32'h3D3D);
      wait_reports(14, 200, "init_report_count");
      for (int i = 0; i < 14; i++) chk($sformatf("init_word%0d", i), 64'(rep_at(i)), 64'(exp_w[i]));
      repeat (6) @(negedge clk);
      chk("init_no_extra", 64'(rep_q.size()), 64'd14);

      // Select ch1, write its config
      base = pop_cnt;
      send(2'd3, 32'd1, "sel_ch1");
      send(2'd0, 32'h0000_00A5, "cfg_ch1");
      chk("cfg_we_tx",     64'(config_we_tx), 64'h2);
      chk("cfg_bus_ch1",   64'(wr_config_tx[31:16]), 64'h00A5);
      chk("cfg_bus_ch0",   64'(wr_config_tx[15:0]), 64'h0);
      chk("cfg_we_rx_idle", 64'(config_we_rx), 64'h0);
      @(negedge clk);
      chk("cfg_we_pulse",  64'(config_we_tx), 64'h0);
      chk("cfg_pop_count", 64'(pop_cnt - base), 64'd2);

      // Busy channel stalls a data write until busy drops
      rd_status_tx = 2'b10;
      base = pop_cnt;
      present(2'd1, 32'hDEAD_BEEF);
      wait_pop(8, ok);
      chk("busy_no_pop",   64'(ok), 64'd0);
      chk("busy_pop_cnt",  64'(pop_cnt - base), 64'd0);
      chk("busy_no_we",    64'(data_we_tx), 64'h0);
      rd_status_tx = 2'b00;
      wait_pop(8, ok);
      fifo_read_empty = 1'b1;
      chk("unbusy_pop",    64'(ok), 64'd1);
      chk("data_we_tx",    64'(data_we_tx), 64'h2);
      chk("data_bus_ch1",  64'(wr_data_tx[63:32]), 64'hDEAD_BEEF);
      chk("data_bus_ch0",  64'(wr_data_tx[31:0]), 64'h0);

      // Invalid channel and DATA to RX are errors; selection stays on ch2
      send(2'd3, 32'd2, "sel_ch2");
      send(2'd3, 32'd7, "sel_bad");
      chk("err_cnt_1",     64'(err_cnt), 64'd1);
      send(2'd1, 32'h0000_1234, "data_rx");
      chk("err_cnt_2",     64'(err_cnt), 64'd2);
      chk("err_no_we",     64'({data_we_tx, config_we_tx, config_we_rx}), 64'h0);
      send(2'd0, 32'h0000_0055, "cfg_ch2");
      chk("cfg_we_rx",     64'(config_we_rx), 64'h1);
      chk("cfg_bus_ch2",   64'(wr_config_rx[15:0]), 64'h0055);
      chk("cfg_tx_quiet",  64'(config_we_tx), 64'h0);
      chk("err_cnt_hold",  64'(err_cnt), 64'd2);

      // Move rr pointer to 1 with a ch1 burst, then ch3 and ch1 change together
      base = rep_q.size();
      config_changed_tx = 2'b10;
      @(negedge clk);
      config_changed_tx = 2'b00;
      wait_reports(base + 3, 50, "ch1_burst_count");
      chk("ch1_burst_head", 64'(rep_at(base)), 64'(w(2'd3, 32'd1)));
      repeat (2) @(negedge clk);
      base = rep_q.size();
      config_changed_rx = 2'b10;
      status_changed_tx = 2'b10;
      @(negedge clk);
      config_changed_rx = 2'b00;
      status_changed_tx = 2'b00;
      wait_reports(base + 7, 80, "rr_burst_count");
      exp_w[0] = w(2'd3, 32'd3); exp_w[1] = w(2'd0, 32'h3C3C); exp_w[2] = w(2'd2, 32'h0030);
      exp_w[3] = w(2'd1, 32'h3D3D);
      exp_w[4] = w(2'd3, 32'd1); exp_w[5] = w(2'd0, 32'h1B1B); exp_w[6] = w(2'd2, 32'd0);
      for (int i = 0; i < 7; i++) chk($sformatf("rr_word%0d", i), 64'(rep_at(base + i)), 64'(exp_w[i]));

      // Report FIFO full mid-burst: word held, status sampled when pushed
      repeat (2) @(negedge clk);
      base = rep_q.size();
      config_changed_rx = 2'b01;
      @(negedge clk);
      config_changed_rx = 2'b00;
      wait_reports(base + 2, 50, "full_pre_count");
      fifo_write_full = 1'b1;
      rd_status_rx[15:0] = 16'h0022;
      snap = rep_q.size();
      repeat (5) @(negedge clk);
      chk("full_no_push",  64'(rep_q.size()), 64'(snap));
      chk("full_inc_low",  64'(fifo_write_inc), 64'd0);
      fifo_write_full = 1'b0;
      wait_reports(base + 4, 50, "full_resume_count");
      repeat (4) @(negedge clk);
      chk("full_no_extra", 64'(rep_q.size()), 64'(base + 4));
      exp_w[0] = w(2'd3, 32'd2); exp_w[1] = w(2'd0, 32'h2C2C); exp_w[2] = w(2'd2, 32'h0022);
      exp_w[3] = w(2'd1, 32'h2D2D);
      for (int i = 0; i < 4; i++) chk($sformatf("full_word%0d", i), 64'(rep_at(base + i)), 64'(exp_w[i]));

      // Reset mid-burst: both engines abort, full report restarts from ch0
      base = rep_q.size();
      config_changed_tx = 2'b01;
      @(negedge clk);
      config_changed_tx = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_write_inc", 64'(fifo_write_inc), 64'd0);
      chk("rst2_err_cnt",   64'(err_cnt), 64'd0);
      rst_n = 1'b1;
      snap = rep_q.size();
      wait_reports(snap + 14, 200, "rst2_report_count");
      chk("rst2_first_word", 64'(rep_at(snap)), 64'(w(2'd3, 32'd0)));
      chk("rst2_last_word",  64'(rep_at(snap + 13)), 64'(w(2'd1, 32'h3D3D)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
